// File: rtl/rf_op_sequencer.sv
// ============================================================================
// rf_op_sequencer
// ----------------------------------------------------------------------------
// Runs one register-file instruction at a time through a fixed four-state
// sequence: IDLE -> READ -> EXEC -> WRITE -> IDLE. A command is accepted in
// IDLE. Its source registers are read in READ. The ALU result and flags are
// computed in EXEC. The destination register is written in WRITE. Each
// command takes exactly four cycles, so a dependent command that follows
// immediately always reads the value the previous command wrote.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_op                   000 MOV, 001 LDI, 010 ADD, 011 SUB,
//                            100 AND, 101 OR,  110 XOR, 111 CMP
//   cmd_rd/rs1/rs2           destination and source register indices
//   cmd_imm                  immediate operand for LDI
//   read_addr1/2             register file read addresses
//   read_data1/2             register file read data (combinational)
//   write_en/addr/data       register file write port (one cycle in WRITE)
//   done                     one-cycle completion pulse in WRITE
//   busy                     inverse of cmd_ready
//   flag_z, flag_c           zero flag (every op), carry/borrow (ADD/SUB/CMP)
// ============================================================================
module rf_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs1,
    input  logic [2:0] cmd_rs2,
    input  logic [7:0] cmd_imm,
    output logic [2:0] read_addr1,
    output logic [2:0] read_addr2,
    input  logic [7:0] read_data1,
    input  logic [7:0] read_data2,
    output logic       write_en,
    output logic [2:0] write_addr,
    output logic [7:0] write_data,
    output logic       done,
    output logic       busy,
    output logic       flag_z,
    output logic       flag_c
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } op_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;

    // Latched command fields
    op_t        r_op;
    logic [2:0] r_rd;
    logic [2:0] r_rs1;
    logic [2:0] r_rs2;
    logic [7:0] r_imm;

    // Captured operands and registered results
    logic [7:0] r_opa;
    logic [7:0] r_opb;
    logic [7:0] r_result;
    logic       r_flag_z;
    logic       r_flag_c;

    // Combinational ALU outputs
    logic       w_accept;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_result;
    logic       w_carry;
    logic       w_carry_update;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // NOTE: reset is asynchronous, so it is in the sensitivity list. This lets
    // an abort in any state take effect at once, without waiting for a clock
    // edge. All sequential state uses non-blocking (<=) assignments, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case. This
    // stops the tool from inferring a latch on any path that is not covered.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_READ;
            ST_READ:  w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        write_en  = 1'b0;
        case (r_state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_WRITE: begin
                done     = 1'b1;
                // CMP completes like any other op but updates only the flags.
                write_en = (r_op != OP_CMP);
            end
            default: ;
        endcase
        busy = ~cmd_ready;
    end

    // ------------------------------------------------------------------
    // Command latch: loaded only on accept. Later activity on cmd_* is
    // ignored until the next accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= OP_MOV;
            r_rd  <= 3'd0;
            r_rs1 <= 3'd0;
            r_rs2 <= 3'd0;
            r_imm <= 8'd0;
        end else if (w_accept) begin
            r_op  <= op_t'(cmd_op);
            r_rd  <= cmd_rd;
            r_rs1 <= cmd_rs1;
            r_rs2 <= cmd_rs2;
            r_imm <= cmd_imm;
        end
    end

    // The read addresses come straight from the latched sources. They are
    // valid in READ, and they keep their last value in every other state.
    assign read_addr1 = r_rs1;
    assign read_addr2 = r_rs2;

    // ------------------------------------------------------------------
    // Operand capture at the READ -> EXEC edge. The operands are taken
    // before any write of this command, so rd may alias a source.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa <= 8'd0;
            r_opb <= 8'd0;
        end else if (r_state == ST_READ) begin
            r_opa <= read_data1;
            r_opb <= read_data2;
        end
    end

    // ------------------------------------------------------------------
    // ALU (EXEC). Nine-bit add and subtract: bit 8 of the sum is the carry,
    // and bit 8 of the difference is the unsigned borrow (rs1 < rs2).
    // ------------------------------------------------------------------
    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

    always_comb begin
        w_result       = 8'd0;
        w_carry        = r_flag_c;
        w_carry_update = 1'b0;
        case (r_op)
            OP_MOV: w_result = r_opa;
            OP_LDI: w_result = r_imm;
            OP_ADD: begin
                w_result       = w_sum[7:0];
                w_carry        = w_sum[8];
                w_carry_update = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                w_result       = w_diff[7:0];
                w_carry        = w_diff[8];
                w_carry_update = 1'b1;
            end
            OP_AND: w_result = r_opa & r_opb;
            OP_OR:  w_result = r_opa | r_opb;
            OP_XOR: w_result = r_opa ^ r_opb;
            default: w_result = 8'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result and flags are registered at the EXEC -> WRITE edge. The carry
    // flag keeps its old value for ops that do not define it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 8'd0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result <= w_result;
            r_flag_z <= (w_result == 8'd0);
            if (w_carry_update) begin
                r_flag_c <= w_carry;
            end
        end
    end

    assign write_addr = r_rd;
    assign write_data = r_result;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// ============================================================================
// tb_rf_op_sequencer
// ----------------------------------------------------------------------------
// The bench models the register file around the sequencer. A driver issues
// directed and random commands. When a command is accepted, a behavioural
// model computes the expected write and flags using plain arithmetic, and
// the expectation is queued. A separate monitor pops the queue on every done
// pulse and compares the DUT outputs against it.
// ============================================================================
module tb_rf_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs1;
    logic [2:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [2:0] read_addr1;
    logic [2:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;
    logic       write_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic       done;
    logic       busy;
    logic       flag_z;
    logic       flag_c;

    rf_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .done       (done),
        .busy       (busy),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    // ------------------------------------------------------------------
    // Clock, cycle counter, external register file
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [8];
    assign read_data1 = mem[read_addr1];
    assign read_data2 = mem[read_addr2];
    always @(posedge clk) if (write_en) mem[write_addr] <= write_data;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] imm;
    } cmd_t;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_rf [8];
    logic       ref_c;

    function automatic cmd_t mk(input int op, input int rd, input int rs1,
                                input int rs2, input int imm);
        cmd_t c;
        c.op  = op[2:0];
        c.rd  = rd[2:0];
        c.rs1 = rs1[2:0];
        c.rs2 = rs2[2:0];
        c.imm = imm[7:0];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Computes what the command must do from the architectural rules.
    task automatic model_exec(input cmd_t c, output exp_t e);
        int a;
        int b;
        int r;
        a = int'(ref_rf[c.rs1]);
        b = int'(ref_rf[c.rs2]);
        r = 0;
        case (c.op)
            3'd0: r = a;
            3'd1: r = int'(c.imm);
            3'd2: begin r = a + b; ref_c = (r > 255); r = r % 256; end
            3'd3, 3'd7: begin ref_c = (a < b); r = (a - b + 256) % 256; end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = 0;
        endcase
        e.we   = (c.op != 3'd7);
        e.addr = c.rd;
        e.data = r[7:0];
        e.z    = (r == 0);
        e.c    = ref_c;
        e.cyc  = 0;
        if (e.we) ref_rf[c.rd] = r[7:0];
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
                check("write_en_outside_done", {31'd0, write_en & ~done}, 32'd0);
                if (done) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: done=1 with no command outstanding (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("write_en", {31'd0, write_en}, {31'd0, e.we});
                        if (e.we) begin
                            check("write_addr", {29'd0, write_addr}, {29'd0, e.addr});
                            check("write_data", {24'd0, write_data}, {24'd0, e.data});
                        end
                        check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                        check("flag_c", {31'd0, flag_c}, {31'd0, e.c});
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    task automatic issue(input cmd_t c, input bit push, output int acc);
        int   n;
        exp_t e;
        cmd_op    = c.op;
        cmd_rd    = c.rd;
        cmd_rs1   = c.rs1;
        cmd_rs2   = c.rs2;
        cmd_imm   = c.imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready=0 for %0d cycles, expected 1", n);
        end else begin
            @(posedge clk);
            if (push) begin
                model_exec(c, e);
                e.cyc = acc + 3;
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Toggles the command inputs while the block is busy, then waits for IDLE.
    task automatic scramble_until_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            cmd_op    = 3'($urandom);
            cmd_rd    = 3'($urandom);
            cmd_rs1   = 3'($urandom);
            cmd_rs2   = 3'($urandom);
            cmd_imm   = 8'($urandom);
            cmd_valid = 1'($urandom);
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int a0;
        int a1;
        int a2;
        int mode;
        cmd_t c;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rd    = 3'd0;
        cmd_rs1   = 3'd0;
        cmd_rs2   = 3'd0;
        cmd_imm   = 8'd0;
        ref_c     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem[i]    = 8'($urandom);
            ref_rf[i] = mem[i];
        end

        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_write_addr", {29'd0, write_addr}, 32'd0);
        check("rst_write_data", {24'd0, write_data}, 32'd0);
        check("rst_read_addrs", {26'd0, read_addr1, read_addr2}, 32'd0);
        check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LDI r3, 0x5A
        issue(mk(1, 3, 0, 0, 8'h5A), 1'b1, a0);
        scramble_until_ready();

        // ADD with carry out, then XOR to zero keeps the carry
        issue(mk(1, 1, 0, 0, 8'hF0), 1'b1, a0);
        scramble_until_ready();
        issue(mk(1, 2, 0, 0, 8'h20), 1'b1, a0);
        scramble_until_ready();
        issue(mk(2, 4, 1, 2, 0), 1'b1, a0);
        scramble_until_ready();
        issue(mk(6, 5, 4, 4, 0), 1'b1, a0);
        scramble_until_ready();

        // CMP sets borrow without writing, then SUB clears it
        issue(mk(1, 1, 0, 0, 8'h10), 1'b1, a0);
        scramble_until_ready();
        issue(mk(7, 6, 1, 2, 0), 1'b1, a0);
        scramble_until_ready();
        issue(mk(3, 6, 2, 1, 0), 1'b1, a0);
        scramble_until_ready();

        // Dependent chain with cmd_valid held high
        issue(mk(1, 1, 0, 0, 8'h01), 1'b1, a0);
        issue(mk(2, 1, 1, 1, 0), 1'b1, a1);
        issue(mk(2, 1, 1, 1, 0), 1'b1, a2);
        check("chain_spacing_1", a1 - a0, 32'd4);
        check("chain_spacing_2", a2 - a1, 32'd4);
        scramble_until_ready();

        // Abort ADD r7 in EXEC with an asynchronous reset
        issue(mk(2, 7, 1, 2, 0), 1'b0, a0);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        ref_c = 1'b0;
        #1;
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_write_en", {31'd0, write_en}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_write_port", {21'd0, write_addr, write_data}, 32'd0);
        check("abort_read_addrs", {26'd0, read_addr1, read_addr2}, 32'd0);
        check("abort_flags", {30'd0, flag_z, flag_c}, 32'd0);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        // r7 must still hold its pre-abort value
        issue(mk(0, 0, 7, 0, 0), 1'b1, a0);
        scramble_until_ready();

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            c = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 255)));
            issue(c, 1'b1, a0);
            mode = int'($urandom_range(0, 2));
            if (mode != 0) scramble_until_ready();
            if (mode == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        cmd_valid = 1'b0;
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_op_sequencer.md
RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

Interface
REQ-001 The block SHALL have no parameters; data is fixed at 8 bits and register addresses at 3 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high (clk, rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  operation code (REQ-014).
REQ-008 cmd_rd / cmd_rs1 / cmd_rs2  input  3 each  destination, source 1 and source 2 register indices.
REQ-009 cmd_imm  input  8  immediate operand.
REQ-010 read_addr1 / read_addr2  output  3 each  register file read addresses.
REQ-011 read_data1 / read_data2  input  8 each  register file read data, combinational from the read addresses.
REQ-012 write_en  output  1, write_addr  output  3, write_data  output  8  register file write port.
REQ-013 done  output  1 (single-cycle completion pulse); busy  output  1; flag_z  output  1; flag_c  output  1.

Function
REQ-014 Opcodes SHALL be decoded as follows.
- 000 MOV: rd = rs1
- 001 LDI: rd = imm
- 010 ADD: rd = rs1 + rs2
- 011 SUB: rd = rs1 - rs2
- 100 AND, 101 OR, 110 XOR: rd = rs1 op rs2
- 111 CMP: rs1 - rs2, flags only, no write
REQ-015 The FSM SHALL have states IDLE, READ, EXEC and WRITE, and advance one state per clock.
- IDLE to READ on accept.
- READ to EXEC.
- EXEC to WRITE.
- WRITE to IDLE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-017 On accept, the block SHALL latch op, rd, rs1, rs2 and imm; later changes on the cmd_* inputs SHALL have no effect until the next accept.
REQ-018 In READ, read_addr1 and read_addr2 SHALL equal the latched rs1 and rs2, and operands SHALL be captured from read_data1/read_data2 at the READ-to-EXEC edge.
REQ-019 In EXEC, the 8-bit result and the flags SHALL be computed from the captured operands and registered at the EXEC-to-WRITE edge.
REQ-020 Arithmetic SHALL be 8-bit modulo 256.
- ADD: flag_c = bit 8 of the 9-bit sum.
- SUB and CMP: flag_c = 1 when rs1 < rs2, unsigned borrow.
REQ-021 flag_z SHALL be 1 when the 8-bit result is 0, and SHALL be updated by every opcode.
REQ-022 flag_c SHALL be updated only by ADD, SUB and CMP, and SHALL hold its value for all other opcodes.
REQ-023 In WRITE, write_en SHALL be 1 for exactly one cycle with write_addr = latched rd and write_data = result; for CMP, write_en SHALL stay 0.
REQ-024 done SHALL be 1 for exactly the WRITE cycle, for every opcode including CMP.
REQ-025 write_en SHALL be 0 in every state other than WRITE.
REQ-026 busy SHALL equal NOT cmd_ready.
REQ-027 Latency SHALL be fixed: accept at edge T0, write_en/done high during T2..T3, register file commits at T3, cmd_ready high again after T3.
REQ-028 Throughput SHALL be one command per 4 cycles.
REQ-029 A dependent command issued back-to-back SHALL observe the prior write, because its READ occurs no earlier than T4.
REQ-030 rs1 = rs2, and rd equal to either source, SHALL be legal and SHALL use the pre-write operand values.
REQ-031 Outside READ, read_addr1 and read_addr2 SHALL hold their last driven values.

Reset
REQ-032 While rst is high, the block SHALL be in IDLE and SHALL drive these output values.
- cmd_ready = 1, busy = 0, done = 0
- write_en = 0, write_addr = 0, write_data = 0
- read_addr1 = read_addr2 = 0
- flag_z = 0, flag_c = 0
- all latched fields = 0
REQ-033 Reset asserted in any state SHALL abort the command without issuing a write; the aborted command SHALL NOT produce a done pulse.

Verification
REQ-034 LDI r3, imm = 0x5A -> write_en, write_addr = 3, write_data = 0x5A in the third cycle after accept; done coincident; flag_z = 0.
REQ-035 With r1 = 0xF0 and r2 = 0x20, ADD r4 = r1 + r2 -> write_data = 0x10, flag_c = 1, flag_z = 0; a following XOR r5 = r4 ^ r4 -> write_data = 0x00, flag_z = 1, flag_c = 1 (held).
REQ-036 With r1 = 0x10 and r2 = 0x20, CMP r1, r2 -> write_en = 0 throughout, done pulses, flag_c = 1, flag_z = 0; SUB r6 = r2 - r1 -> write_data = 0x10, flag_c = 0.
REQ-037 cmd_valid held high with a 3-command dependent chain (LDI r1 = 0x01; ADD r1 = r1 + r1; ADD r1 = r1 + r1) -> accepts exactly 4 cycles apart, final write_data = 0x04, cmd_ready = 0 while busy.
REQ-038 cmd_* inputs changed during READ/EXEC -> result is computed from the accepted values only.
REQ-039 rst asserted asynchronously in EXEC of ADD r7 -> outputs reach their reset values immediately, no write_en and no done follow, and the next command is accepted normally after rst deasserts.
